// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the program counter, drives the instruction
// memory address, and fills the IF/ID pipeline register.
// Handles decode stalls, execute redirects (with bubble insertion) and halt
// detection. Fetch stops on an out-of-range PC or an all-zero instruction word.
// Optional build macro FETCH_PERF_EN adds saturating fetch/stall/redirect
// counters as extra outputs; without it the core behaviour is unchanged.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 32,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
`ifdef FETCH_PERF_EN
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count,
  output logic [15:0] redirect_count,
`endif
  output logic        halted
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // One past the last legal fetch byte address, widened so large memories
  // cannot overflow the comparison.
  localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

  state_t      state;
  logic [31:0] pc_q;

  logic        pc_beyond;
  logic        zero_word;
  logic        stop_fetch;
  logic        run_edge;
  logic        load_evt;
  logic [31:0] redirect_pc;
  logic [31:0] pc_next_seq;

  assign imem_pc = pc_q;

  // Fetch-stop and event decode for the current cycle.
  always_comb begin
    pc_beyond   = ({1'b0, pc_q} >= PC_LIMIT);
    zero_word   = (imem_instr == 32'h0000_0000);
    stop_fetch  = pc_beyond || zero_word;
    run_edge    = !branch_taken && !stall && (state == RUN);
    load_evt    = run_edge && !stop_fetch;
    // Redirect targets are word aligned; stray low address bits are dropped.
    redirect_pc = branch_target & 32'hFFFF_FFFC;
    pc_next_seq = pc_q + 32'd4;
  end

  // Fetch FSM: PC, IF/ID register and halt flag all update here so that
  // every output is registered. Priority: redirect, then stall, then state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= BOOT;
      pc_q       <= RESET_PC;
      ifid_pc    <= 32'h0000_0000;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
      halted     <= 1'b0;
    end else if (branch_taken) begin
      // Redirect squashes whatever was being fetched and restarts fetch,
      // including out of HALT.
      state      <= RUN;
      pc_q       <= redirect_pc;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
      halted     <= 1'b0;
    end else if (!stall) begin
      case (state)
        BOOT: begin
          // Give the memory one cycle to present the reset-PC word.
          state <= RUN;
        end
        RUN: begin
          if (stop_fetch) begin
            state      <= HALT;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
            halted     <= 1'b1;
          end else begin
            ifid_pc    <= pc_q;
            ifid_instr <= imem_instr;
            ifid_valid <= 1'b1;
            pc_q       <= pc_next_seq;
          end
        end
        HALT: begin
          // Frozen until a redirect or reset.
          state <= HALT;
        end
        default: begin
          state      <= HALT;
          ifid_instr <= NOP_INSTR;
          ifid_valid <= 1'b0;
          halted     <= 1'b1;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic stall_evt;
  assign stall_evt = !branch_taken && stall && (state == RUN);

  // Saturating performance counters; they never wrap back to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count    <= 32'h0000_0000;
      stall_count    <= 32'h0000_0000;
      redirect_count <= 16'h0000;
    end else begin
      if (load_evt) begin
        fetch_count <= sat_inc32(fetch_count);
      end
      if (stall_evt) begin
        stall_count <= sat_inc32(stall_count);
      end
      if (branch_taken) begin
        redirect_count <= sat_inc16(redirect_count);
      end
    end
  end
`endif

endmodule
